fc_weight_buffer: RTL and testbench

- Responder on the weight-read interface driven by the FC weight address generator (13-bit address plus read enable).
- Holds FC weights loaded by the DMA write port. Returns read data with fixed 1-cycle latency.
- Frames each 32-beat read burst (one group) and reports burst completion and protocol errors to the NPE/scheduler side.

---
 rtl/fc_pkg.sv | 13 +
 rtl/fc_weight_buffer_if.sv | 31 +++
 rtl/fc_wbuf_ram.sv | 30 +++
 rtl/fc_weight_buffer.sv | 108 ++++++++++
 tb/tb_fc_weight_buffer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared constants and burst FSM encoding for the FC weight buffer slice.
package fc_pkg;
  localparam int         FC_ADDR_W    = 13;
  localparam int         FC_DATA_W    = 128;
  localparam int         FC_GROUP_NUM = 32;
  localparam logic [3:0] FC_MODE      = 4'd2;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_BURST = 2'd1,
    BR_DONE  = 2'd2
  } br_state_e;
endpackage

// File: rtl/fc_weight_buffer_if.sv
// Weight-buffer bus: DMA write port, address-generator read port, burst status.
interface fc_weight_buffer_if import fc_pkg::*; #(
  parameter int ADDR_W = FC_ADDR_W,
  parameter int DATA_W = FC_DATA_W
) ();
  logic              start_calculate;
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic [5:0]        o_beat_cnt;
  logic              o_burst_done;
  logic [7:0]        o_group_cnt;
  logic              o_err_overrun;
  logic              o_err_rw_hazard;

  modport master (
    output start_calculate, i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
    input  o_rd_data, o_rd_valid, o_beat_cnt, o_burst_done, o_group_cnt,
           o_err_overrun, o_err_rw_hazard
  );

  modport slave (
    input  start_calculate, i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
    output o_rd_data, o_rd_valid, o_beat_cnt, o_burst_done, o_group_cnt,
           o_err_overrun, o_err_rw_hazard
  );
endinterface

// File: rtl/fc_wbuf_ram.sv
// Simple dual-port read-first weight RAM, 1-cycle read latency.
module fc_wbuf_ram import fc_pkg::*; #(
  parameter int ADDR_W = FC_ADDR_W,
  parameter int DATA_W = FC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Array has no reset so contents survive rst and map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Non-blocking read of the array gives old data on a same-address write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fc_weight_buffer.sv
// FC weight buffer: RAM responder plus burst framing, group counter and error flags.
module fc_weight_buffer import fc_pkg::*; #(
  parameter int ADDR_W    = FC_ADDR_W,
  parameter int DATA_W    = FC_DATA_W,
  parameter int GROUP_NUM = FC_GROUP_NUM
) (
  input  logic               clk,
  input  logic               rst,
  fc_weight_buffer_if.slave  bus
);
  localparam logic [5:0] LAST_BEAT = 6'(GROUP_NUM - 1);

  br_state_e  state_q, state_d;
  logic       rd_valid_q;
  logic [5:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] group_cnt_q, group_cnt_d;
  logic       err_ov_q, err_ov_d;
  logic       err_rw_q, err_rw_d;
  logic       beat, burst_done, rw_hazard;

  fc_wbuf_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.i_wr_en),
    .waddr_i (bus.i_wr_addr),
    .wdata_i (bus.i_wr_data),
    .re_i    (bus.i_rd_en),
    .raddr_i (bus.i_rd_addr),
    .rdata_o (bus.o_rd_data)
  );

  // Beats are the returned data, not the requests; start_calculate masks them.
  assign beat      = rd_valid_q & ~bus.start_calculate;
  assign rw_hazard = bus.i_wr_en & bus.i_rd_en & (bus.i_wr_addr == bus.i_rd_addr);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    group_cnt_d = group_cnt_q;
    err_ov_d    = err_ov_q;
    err_rw_d    = err_rw_q | rw_hazard;
    burst_done  = 1'b0;
    if (bus.start_calculate) begin
      state_d     = BR_IDLE;
      beat_cnt_d  = '0;
      group_cnt_d = '0;
      err_ov_d    = 1'b0;
      err_rw_d    = 1'b0;
    end else begin
      case (state_q)
        BR_IDLE, BR_DONE: begin
          if (beat) begin
            // A beat right after completion means no idle gap between bursts.
            if (state_q == BR_DONE) err_ov_d = 1'b1;
            if (GROUP_NUM == 1) begin
              burst_done  = 1'b1;
              group_cnt_d = group_cnt_q + 8'd1;
              state_d     = BR_IDLE;
            end else begin
              beat_cnt_d = 6'd1;
              state_d    = BR_BURST;
            end
          end else begin
            state_d = BR_IDLE;
          end
        end
        BR_BURST: begin
          if (beat) begin
            if (beat_cnt_q == LAST_BEAT) begin
              burst_done  = 1'b1;
              beat_cnt_d  = '0;
              group_cnt_d = group_cnt_q + 8'd1;
              state_d     = BR_DONE;
            end else begin
              beat_cnt_d = beat_cnt_q + 6'd1;
            end
          end
        end
        default: state_d = BR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BR_IDLE;
      rd_valid_q  <= 1'b0;
      beat_cnt_q  <= '0;
      group_cnt_q <= '0;
      err_ov_q    <= 1'b0;
      err_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_valid_q  <= bus.i_rd_en;
      beat_cnt_q  <= beat_cnt_d;
      group_cnt_q <= group_cnt_d;
      err_ov_q    <= err_ov_d;
      err_rw_q    <= err_rw_d;
    end
  end

  assign bus.o_rd_valid      = rd_valid_q;
  assign bus.o_beat_cnt      = beat_cnt_q;
  assign bus.o_burst_done    = burst_done;
  assign bus.o_group_cnt     = group_cnt_q;
  assign bus.o_err_overrun   = err_ov_q;
  assign bus.o_err_rw_hazard = err_rw_q;
endmodule

// File: tb/tb_fc_weight_buffer.sv
// Bench for fc_weight_buffer: directed scenarios plus random traffic against a beat-counting model.
module tb_fc_weight_buffer;
  import fc_pkg::*;
  localparam int AW = FC_ADDR_W;
  localparam int DW = FC_DATA_W;
  localparam int GN = FC_GROUP_NUM;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_weight_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fc_weight_buffer #(.ADDR_W(AW), .DATA_W(DW), .GROUP_NUM(GN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory map plus a plain count of returned beats.
  logic [DW-1:0] ref_mem [int];
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  bit            m_known = 1'b1;
  int            m_beats = 0;
  int            m_groups = 0;
  bit            m_ov = 1'b0, m_hz = 1'b0, m_after_done = 1'b0, m_done = 1'b0;
  logic          obs_done;

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_known = 1'b1;
    m_beats = 0; m_groups = 0; m_ov = 1'b0; m_hz = 1'b0; m_after_done = 1'b0; m_done = 1'b0;
  endtask

  // Called at a negedge; drives one cycle, samples done just before the edge.
  task automatic step(input bit st, input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit re, input int ra);
    bit beat;
    bus.start_calculate = st;
    bus.i_wr_en   = we;
    bus.i_wr_addr = wa[AW-1:0];
    bus.i_wr_data = wd;
    bus.i_rd_en   = re;
    bus.i_rd_addr = ra[AW-1:0];
    #4;
    obs_done = bus.o_burst_done;
    @(posedge clk);
    beat   = m_valid && !st;
    m_done = beat && (m_beats + 1 == GN);
    if (st) begin
      m_beats = 0; m_groups = 0; m_ov = 1'b0; m_hz = 1'b0; m_after_done = 1'b0;
    end else begin
      if (we && re && wa == ra) m_hz = 1'b1;
      if (beat) begin
        if (m_after_done) m_ov = 1'b1;
        m_after_done = 1'b0;
        m_beats++;
        if (m_beats == GN) begin
          m_beats = 0;
          m_groups = (m_groups + 1) % 256;
          m_after_done = 1'b1;
        end
      end else begin
        m_after_done = 1'b0;
      end
    end
    if (re) begin
      m_known = ref_mem.exists(ra);
      m_data  = m_known ? ref_mem[ra] : '0;
    end
    m_valid = re;
    if (we) ref_mem[wa] = wd;
    @(negedge clk);
  endtask

  task automatic rd(input int a);       step(1'b0, 1'b0, 0, '0, 1'b1, a); endtask
  task automatic wr(input int a, input logic [DW-1:0] d); step(1'b0, 1'b1, a, d, 1'b0, 0); endtask
  task automatic idle();                step(1'b0, 1'b0, 0, '0, 1'b0, 0); endtask
  task automatic start();               step(1'b1, 1'b0, 0, '0, 1'b0, 0); endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.o_rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset.valid got=%b exp=0", bus.o_rd_valid);
    end
    n_tests++;
    if (bus.o_rd_data !== '0) begin
      n_fail++; $display("FAIL reset.data got=%h exp=0", bus.o_rd_data);
    end
    n_tests++;
    if ({bus.o_beat_cnt, bus.o_group_cnt, bus.o_burst_done, bus.o_err_overrun, bus.o_err_rw_hazard} !== 17'd0) begin
      n_fail++; $display("FAIL reset.status got beat=%0d grp=%0d done=%b ov=%b hz=%b exp all 0",
                         bus.o_beat_cnt, bus.o_group_cnt, bus.o_burst_done, bus.o_err_overrun, bus.o_err_rw_hazard);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single_burst();
    int bad_data = 0, bad_done = 0;
    for (int i = 0; i < GN; i++) wr(32'h100 + i, DW'(i));
    start();
    for (int k = 0; k < GN; k++) begin
      rd(32'h100 + k);
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== DW'(k)) bad_data++;
      if (obs_done !== 1'b0) bad_done++;
    end
    idle();
    n_tests++;
    if (bad_data != 0) begin
      n_fail++; $display("FAIL single.data got %0d bad beats exp 0", bad_data);
    end
    n_tests++;
    if (bad_done != 0) begin
      n_fail++; $display("FAIL single.early_done got %0d early pulses exp 0", bad_done);
    end
    n_tests++;
    if (obs_done !== 1'b1) begin
      n_fail++; $display("FAIL single.done got=%b exp=1", obs_done);
    end
    n_tests++;
    if (bus.o_group_cnt !== 8'd1 || bus.o_beat_cnt !== 6'd0) begin
      n_fail++; $display("FAIL single.counts got grp=%0d beat=%0d exp grp=1 beat=0", bus.o_group_cnt, bus.o_beat_cnt);
    end
  endtask

  task automatic test_gap();
    int bad_hold = 0, bad_data = 0;
    start();
    for (int k = 0; k < 10; k++) rd(32'h100 + k);
    repeat (3) begin
      idle();
      if (bus.o_beat_cnt !== 6'd10) bad_hold++;
    end
    for (int k = 10; k < GN; k++) begin
      rd(32'h100 + k);
      if (bus.o_rd_data !== DW'(k)) bad_data++;
    end
    idle();
    n_tests++;
    if (bad_hold != 0) begin
      n_fail++; $display("FAIL gap.hold got %0d cycles with beat_cnt!=10 exp 0", bad_hold);
    end
    n_tests++;
    if (bad_data != 0) begin
      n_fail++; $display("FAIL gap.data got %0d bad beats exp 0", bad_data);
    end
    n_tests++;
    if (obs_done !== 1'b1 || bus.o_group_cnt !== 8'd1) begin
      n_fail++; $display("FAIL gap.done got done=%b grp=%0d exp done=1 grp=1", obs_done, bus.o_group_cnt);
    end
    n_tests++;
    if (bus.o_err_overrun !== 1'b0 || bus.o_err_rw_hazard !== 1'b0) begin
      n_fail++; $display("FAIL gap.errors got ov=%b hz=%b exp 0 0", bus.o_err_overrun, bus.o_err_rw_hazard);
    end
  endtask

  task automatic test_back_to_back(input int gap);
    int dones = 0;
    start();
    for (int k = 0; k < GN; k++) begin rd(32'h100 + k); dones += int'(obs_done); end
    for (int g = 0; g < gap; g++) begin idle(); dones += int'(obs_done); end
    for (int k = 0; k < GN; k++) begin rd(32'h100 + k); dones += int'(obs_done); end
    idle(); dones += int'(obs_done);
    n_tests++;
    if (dones != 2 || bus.o_group_cnt !== 8'd2) begin
      n_fail++; $display("FAIL b2b.gap%0d got dones=%0d grp=%0d exp 2 2", gap, dones, bus.o_group_cnt);
    end
    n_tests++;
    if (bus.o_err_overrun !== (gap == 0)) begin
      n_fail++; $display("FAIL b2b.gap%0d.overrun got=%b exp=%b", gap, bus.o_err_overrun, gap == 0);
    end
  endtask

  task automatic test_rw_hazard();
    logic [DW-1:0] v_old, v_new;
    v_old = DW'(16'h5555);
    v_new = DW'(16'hAAAA);
    start();
    wr(32'h200, v_old);
    n_tests++;
    if (bus.o_err_rw_hazard !== 1'b0) begin
      n_fail++; $display("FAIL hazard.plain_write got=%b exp=0", bus.o_err_rw_hazard);
    end
    step(1'b0, 1'b1, 32'h200, v_new, 1'b1, 32'h200);
    n_tests++;
    if (bus.o_rd_data !== v_old || bus.o_err_rw_hazard !== 1'b1) begin
      n_fail++; $display("FAIL hazard.read_first got data=%h hz=%b exp data=%h hz=1", bus.o_rd_data, bus.o_err_rw_hazard, v_old);
    end
    rd(32'h200);
    n_tests++;
    if (bus.o_rd_data !== v_new || bus.o_err_rw_hazard !== 1'b1) begin
      n_fail++; $display("FAIL hazard.new_data got data=%h hz=%b exp data=%h hz=1", bus.o_rd_data, bus.o_err_rw_hazard, v_new);
    end
    idle();
  endtask

  task automatic test_reset_mid_burst();
    start();
    for (int k = 0; k < GN + 16; k++) rd(32'h100 + (k % GN));
    n_tests++;
    if (bus.o_beat_cnt !== 6'd15 || bus.o_group_cnt !== 8'd1 || bus.o_err_overrun !== 1'b1) begin
      n_fail++; $display("FAIL rstmid.pre got beat=%0d grp=%0d ov=%b exp 15 1 1", bus.o_beat_cnt, bus.o_group_cnt, bus.o_err_overrun);
    end
    bus.i_rd_en = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.o_rd_valid, bus.o_beat_cnt, bus.o_group_cnt, bus.o_burst_done, bus.o_err_overrun, bus.o_err_rw_hazard} !== 18'd0
        || bus.o_rd_data !== '0) begin
      n_fail++; $display("FAIL rstmid.async got v=%b beat=%0d grp=%0d done=%b ov=%b data=%h exp all 0",
                         bus.o_rd_valid, bus.o_beat_cnt, bus.o_group_cnt, bus.o_burst_done, bus.o_err_overrun, bus.o_rd_data);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < GN; k++) begin
      rd(32'h100 + ((k + 5) % GN));
      if (k == 0) begin
        n_tests++;
        if (bus.o_rd_data !== DW'(5)) begin
          n_fail++; $display("FAIL rstmid.retained got=%h exp=5", bus.o_rd_data);
        end
      end
    end
    idle();
    n_tests++;
    if (bus.o_group_cnt !== 8'd1) begin
      n_fail++; $display("FAIL rstmid.group got=%0d exp=1", bus.o_group_cnt);
    end
  endtask

  task automatic test_start_clear();
    start();
    for (int k = 0; k < 5 * GN; k++) rd(32'h100 + (k % GN));
    step(1'b0, 1'b1, 32'h200, DW'(32'h1234), 1'b1, 32'h200);
    n_tests++;
    if (bus.o_group_cnt !== 8'd5 || bus.o_err_overrun !== 1'b1 || bus.o_err_rw_hazard !== 1'b1) begin
      n_fail++; $display("FAIL startclr.pre got grp=%0d ov=%b hz=%b exp 5 1 1", bus.o_group_cnt, bus.o_err_overrun, bus.o_err_rw_hazard);
    end
    start();
    n_tests++;
    if (obs_done !== 1'b0 || bus.o_group_cnt !== 8'd0 || bus.o_beat_cnt !== 6'd0
        || bus.o_err_overrun !== 1'b0 || bus.o_err_rw_hazard !== 1'b0) begin
      n_fail++; $display("FAIL startclr.cleared got done=%b grp=%0d beat=%0d ov=%b hz=%b exp all 0",
                         obs_done, bus.o_group_cnt, bus.o_beat_cnt, bus.o_err_overrun, bus.o_err_rw_hazard);
    end
    idle();
    rd(32'h100);
    idle();
    n_tests++;
    if (bus.o_beat_cnt !== 6'd1 || bus.o_err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL startclr.idle_state got beat=%0d ov=%b exp 1 0", bus.o_beat_cnt, bus.o_err_overrun);
    end
  endtask

  task automatic test_random();
    int bad_done = 0, bad_valid = 0, bad_stat = 0, bad_data = 0;
    bit st, we, re;
    int wa, ra;
    logic [DW-1:0] wd;
    for (int c = 0; c < 1200; c++) begin
      st = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 9) < 8);
      wa = 32'h400 + int'($urandom_range(0, 15));
      ra = 32'h400 + int'($urandom_range(0, 15));
      wd = {$urandom, $urandom, $urandom, $urandom};
      step(st, we, wa, wd, re, ra);
      if (obs_done !== m_done) bad_done++;
      if (bus.o_rd_valid !== m_valid) bad_valid++;
      if ({bus.o_beat_cnt, bus.o_group_cnt, bus.o_err_overrun, bus.o_err_rw_hazard}
          !== {6'(m_beats), 8'(m_groups), m_ov, m_hz}) bad_stat++;
      if (m_known && bus.o_rd_data !== m_data) bad_data++;
    end
    n_tests++;
    if (bad_done != 0) begin n_fail++; $display("FAIL rand.done got %0d bad cycles exp 0", bad_done); end
    n_tests++;
    if (bad_valid != 0) begin n_fail++; $display("FAIL rand.valid got %0d bad cycles exp 0", bad_valid); end
    n_tests++;
    if (bad_stat != 0) begin n_fail++; $display("FAIL rand.status got %0d bad cycles exp 0", bad_stat); end
    n_tests++;
    if (bad_data != 0) begin n_fail++; $display("FAIL rand.data got %0d bad cycles exp 0", bad_data); end
  endtask

  initial begin
    rst = 1'b0;
    bus.start_calculate = 1'b0;
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_rd_en = 1'b0; bus.i_rd_addr = '0;
    test_reset();
    test_single_burst();
    test_gap();
    test_back_to_back(1);
    test_back_to_back(0);
    test_rw_hazard();
    test_reset_mid_burst();
    test_start_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
